regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Arbitrates several writeback sources onto the register file's single registered write port.
// Define REGFILE_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (source 0 highest).
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      hold,
    output logic                      Reg_Write,
    output logic [ADDR_W-1:0]         Reg_input_address,
    output logic [DATA_W-1:0]         Reg_input_data,
    output logic [2**ADDR_W-1:0]      pending_mask,
    output logic [1:0]                grant_id
);

    logic [NUM_REQ-1:0] full;
    logic [ADDR_W-1:0]  buf_addr [NUM_REQ];
    logic [DATA_W-1:0]  buf_data [NUM_REQ];

    logic               grant_valid;
    logic [1:0]         grant_idx;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [NUM_REQ-1:0] accept;

`ifdef REGFILE_ARB_RR_EN
    logic [1:0] last_ptr;
    logic [1:0] cand;

    // NOTE: every variable in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (!hold) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = 2'((int'(last_ptr) + k) % NUM_REQ);
                if (!grant_valid && full[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            last_ptr <= 2'(NUM_REQ - 1);
        end else if (grant_valid) begin
            last_ptr <= grant_idx;
        end
    end
`else
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (!hold) begin
            // Descending scan: the lowest full index is written last and wins.
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (full[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = 2'(i);
                end
            end
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_onehot[i] = grant_valid && (grant_idx == 2'(i));
            req_ready[i]    = !full[i] || grant_onehot[i];
            // Writes to register 0 complete the handshake but are dropped here.
            accept[i]       = req_valid[i] && req_ready[i] &&
                              (req_addr[i*ADDR_W +: ADDR_W] != '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            full <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    full[i] <= 1'b1;
                end else if (grant_onehot[i]) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    // NOTE: buffer payload is not reset; the full flag alone qualifies it.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                buf_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
                buf_data[i] <= req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            Reg_Write         <= 1'b0;
            Reg_input_address <= '0;
            Reg_input_data    <= '0;
            grant_id          <= '0;
        end else if (grant_valid) begin
            Reg_Write         <= 1'b1;
            Reg_input_address <= buf_addr[grant_idx];
            Reg_input_data    <= buf_data[grant_idx];
            grant_id          <= grant_idx;
        end else begin
            Reg_Write         <= 1'b0;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (full[i]) begin
                pending_mask[buf_addr[i]] = 1'b1;
            end
        end
        if (Reg_Write) begin
            pending_mask[Reg_input_address] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (3 sources, 16-bit data, 8 registers).
// Expectations follow REGFILE_ARB_RR_EN when it is defined for the build.
module tb_regfile_write_arbiter;

    localparam int NR = 3;
    localparam int DW = 16;
    localparam int AW = 3;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             hold;
    logic             reg_write;
    logic [AW-1:0]    reg_addr;
    logic [DW-1:0]    reg_data;
    logic [7:0]       pending_mask;
    logic [1:0]       grant_id;

    int checks = 0;
    int errors = 0;

    int exp_grant [6];

    regfile_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK               (clk),
        .Reset             (rst),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .hold              (hold),
        .Reg_Write         (reg_write),
        .Reg_input_address (reg_addr),
        .Reg_input_data    (reg_data),
        .pending_mask      (pending_mask),
        .grant_id          (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic check_port(input string tag, input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [1:0] g);
        check({tag, ".we"},    32'(reg_write), 32'(we));
        check({tag, ".addr"},  32'(reg_addr),  32'(a));
        check({tag, ".data"},  32'(reg_data),  32'(d));
        check({tag, ".grant"}, 32'(grant_id),  32'(g));
    endtask

    task automatic check_reset_state(input string tag);
        check_port(tag, 1'b0, 3'd0, 16'h0000, 2'd0);
        check({tag, ".pending"}, 32'(pending_mask), 32'h00);
        check({tag, ".ready"},   32'(req_ready),    32'h7);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        hold      = 1'b0;

`ifdef REGFILE_ARB_RR_EN
        exp_grant = '{0, 1, 2, 0, 1, 2};
`else
        exp_grant = '{0, 0, 0, 0, 0, 0};
`endif

        // Reset state
        #1;
        check_reset_state("reset");
        @(posedge clk);
        tick();
        rst = 1'b0;

        // Single write: src1 -> r5 = 0xBEEF
        set_req(1, 3'd5, 16'hBEEF);
        #1;
        check("single.ready1", 32'(req_ready[1]), 32'h1);
        tick();
        req_valid = '0;
        #1;
        check("single.pend_buf", 32'(pending_mask), 32'h20);
        check("single.we_early", 32'(reg_write), 32'h0);
        tick();
        check_port("single.port", 1'b1, 3'd5, 16'hBEEF, 2'd1);
        check("single.pend_port", 32'(pending_mask), 32'h20);
        tick();
        check_port("single.after", 1'b0, 3'd5, 16'hBEEF, 2'd1);
        check("single.pend_clr", 32'(pending_mask), 32'h00);

        // Address 0 is accepted but discarded
        set_req(0, 3'd0, 16'h1234);
        #1;
        check("zero.ready0", 32'(req_ready[0]), 32'h1);
        tick();
        req_valid = '0;
        #1;
        check("zero.pend", 32'(pending_mask), 32'h00);
        check("zero.ready", 32'(req_ready), 32'h7);
        check("zero.we0", 32'(reg_write), 32'h0);
        tick();
        check("zero.we1", 32'(reg_write), 32'h0);
        check("zero.pend1", 32'(pending_mask), 32'h00);
        tick();
        check("zero.we2", 32'(reg_write), 32'h0);

        // Contention: all sources stream to r1/r2/r3
        set_req(0, 3'd1, 16'h1111);
        set_req(1, 3'd2, 16'h2222);
        set_req(2, 3'd3, 16'h3333);
        tick();
        check("cont.we_first", 32'(reg_write), 32'h0);
        check("cont.pend", 32'(pending_mask), 32'h0E);
        for (int c = 0; c < 6; c++) begin
            tick();
            check_port($sformatf("cont.c%0d", c), 1'b1, 3'(exp_grant[c] + 1),
                       16'(32'h1111 * (exp_grant[c] + 1)), 2'(exp_grant[c]));
        end
        req_valid = '0;
        repeat (5) tick();
        check("cont.drain_we", 32'(reg_write), 32'h0);
        check("cont.drain_pend", 32'(pending_mask), 32'h00);
        check("cont.drain_ready", 32'(req_ready), 32'h7);

        // Same address from src0 and src2 from reset-state arbitration
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 3'd4, 16'h0001);
        set_req(2, 3'd4, 16'h0002);
        tick();
        req_valid = '0;
        #1;
        check("same.pend_buf", 32'(pending_mask), 32'h10);
        tick();
        check_port("same.first", 1'b1, 3'd4, 16'h0001, 2'd0);
        check("same.pend1", 32'(pending_mask), 32'h10);
        tick();
        check_port("same.second", 1'b1, 3'd4, 16'h0002, 2'd2);
        check("same.pend2", 32'(pending_mask), 32'h10);
        tick();
        check_port("same.final", 1'b0, 3'd4, 16'h0002, 2'd2);
        check("same.pend3", 32'(pending_mask), 32'h00);

        // hold with two full buffers
        hold = 1'b1;
        set_req(0, 3'd6, 16'hA5A5);
        set_req(1, 3'd7, 16'h5A5A);
        tick();
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("hold.we%0d", c),    32'(reg_write),    32'h0);
            check($sformatf("hold.ready%0d", c), 32'(req_ready),    32'h4);
            check($sformatf("hold.pend%0d", c),  32'(pending_mask), 32'hC0);
            tick();
        end
        hold = 1'b0;
        tick();
        check_port("hold.drain0", 1'b1, 3'd6, 16'hA5A5, 2'd0);
        tick();
        check_port("hold.drain1", 1'b1, 3'd7, 16'h5A5A, 2'd1);
        tick();
        check("hold.we_end", 32'(reg_write), 32'h0);
        check("hold.pend_end", 32'(pending_mask), 32'h00);

        // Reset mid-stream
        set_req(0, 3'd3, 16'h7777);
        set_req(1, 3'd2, 16'h8888);
        tick();
        req_valid = '0;
        tick();
        check("rst.we_pre", 32'(reg_write), 32'h1);
        check("rst.pend_pre", 32'(pending_mask), 32'h0C);
        #1;
        rst = 1'b1;
        #1;
        check_reset_state("rst.async");
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rst.we_after%0d", c),   32'(reg_write),    32'h0);
            check($sformatf("rst.pend_after%0d", c), 32'(pending_mask), 32'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
